rt_frame_ctrl: RTL and testbench



---
 rtl/rt_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_rt_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_frame_ctrl.sv
// Avalon-MM run controller for the raytracer: issues a one-cycle start pulse,
// tracks the frame until rt_done or timeout, and reports status, counters and irq.
module rt_frame_ctrl #(
    parameter int unsigned CYC_W = 32,
    parameter int unsigned FRM_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_s0_address,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    output logic        start_rt,
    input  logic        rt_done,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMP_W  = DATA_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_LIM    = 3'd2;
    localparam logic [2:0] A_CYCLES = 3'd3;
    localparam logic [2:0] A_FRAMES = 3'd4;

    logic [1:0]        state_q,  state_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q,   done_d;
    logic              tmo_q,    tmo_d;
    logic [DATA_W-1:0] lim_q,    lim_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [FRM_W-1:0]  frames_q, frames_d;
    logic              start_q,  start_d;
    logic              irq_q,    irq_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;

    logic              wr_ctrl;
    logic              busy;
    logic [CMP_W-1:0]  cyc_inc;

    assign wr_ctrl = avs_s0_write && (avs_s0_address == A_CTRL);
    assign busy    = (state_q != ST_IDLE);
    // Unsaturated count of this RUN cycle, widened so the compare never wraps.
    assign cyc_inc = CMP_W'(cycles_q) + CMP_W'(1);

    // Next-state, CSR and counter logic.
    always_comb begin
        state_d  = state_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        tmo_d    = tmo_q;
        lim_d    = lim_q;
        cycles_d = cycles_q;
        frames_d = frames_q;
        start_d  = 1'b0;

        if (wr_ctrl) begin
            irq_en_d = avs_s0_writedata[1];
            if (avs_s0_writedata[2]) begin
                done_d = 1'b0;
                tmo_d  = 1'b0;
            end
        end
        if (avs_s0_write && (avs_s0_address == A_LIM)) begin
            lim_d = avs_s0_writedata;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && avs_s0_writedata[0]) begin
                    state_d  = ST_ARM;
                    start_d  = 1'b1;
                    cycles_d = '0;
                    done_d   = 1'b0;
                    tmo_d    = 1'b0;
                end
            end
            ST_ARM: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cycles_q != {CYC_W{1'b1}}) begin
                    cycles_d = cycles_q + CYC_W'(1);
                end
                // Completion overrides a same-cycle CLEAR.
                if (rt_done) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    frames_d = frames_q + FRM_W'(1);
                end else if ((lim_q != '0) && (cyc_inc >= CMP_W'(lim_q))) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    tmo_d    = 1'b1;
                    frames_d = frames_q + FRM_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        irq_d = irq_en_q & done_q;
    end

    // Registered read mux, latency one.
    always_comb begin
        rdata_d = '0;
        if (avs_s0_read) begin
            case (avs_s0_address)
                A_CTRL:   rdata_d = DATA_W'({irq_en_q, 1'b0});
                A_STATUS: rdata_d = DATA_W'({irq_q, tmo_q, done_q, busy});
                A_LIM:    rdata_d = lim_q;
                A_CYCLES: rdata_d = DATA_W'(cycles_q);
                A_FRAMES: rdata_d = DATA_W'(frames_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            lim_q    <= '0;
            cycles_q <= '0;
            frames_q <= '0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            lim_q    <= lim_d;
            cycles_q <= cycles_d;
            frames_q <= frames_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign start_rt        = start_q;
    assign irq             = irq_q;
    assign avs_s0_readdata = rdata_q;

endmodule

// File: tb/tb_rt_frame_ctrl.sv
// Self-checking bench for rt_frame_ctrl: CSR vector table plus frame sequences,
// reads checked through an expected-value queue.
module tb_rt_frame_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        start_rt;
    logic        rt_done;
    logic        irq;

    rt_frame_ctrl #(.CYC_W(32), .FRM_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_address   (address),
        .avs_s0_read      (read),
        .avs_s0_readdata  (readdata),
        .avs_s0_write     (write),
        .avs_s0_writedata (writedata),
        .start_rt         (start_rt),
        .rt_done          (rt_done),
        .irq              (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned pulses = 0;
    always @(negedge clk) if (start_rt) pulses <= pulses + 1;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int unsigned p0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk(e.name, readdata, e.exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        read = 1'b1; address = a;
        sb.push_back('{nm, exp});
        @(negedge clk);
        read = 1'b0;
        sb_check();
    endtask

    task automatic do_reset();
        reset = 1'b1; rt_done = 1'b0; read = 1'b0; write = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; rt_done = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_start_rt", 32'(start_rt), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_readdata", readdata, 32'h0);

        // CSR access table
        vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0, "rst_ctrl"});
        vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0, "rst_status"});
        vecs.push_back('{1'b0, 3'd2, 32'h0, 32'h0, "rst_lim"});
        vecs.push_back('{1'b0, 3'd3, 32'h0, 32'h0, "rst_cycles"});
        vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0, "rst_frames"});
        vecs.push_back('{1'b1, 3'd2, 32'hDEADBEEF, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd2, 32'h0, 32'hDEADBEEF, "lim_rw"});
        vecs.push_back('{1'b1, 3'd0, 32'h2, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h2, "ctrl_irq_en"});
        vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0, "status_idle"});
        vecs.push_back('{1'b1, 3'd1, 32'hF, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0, "status_ro"});
        vecs.push_back('{1'b1, 3'd0, 32'h0, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0, "ctrl_clr_en"});
        vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0, "unmapped5"});
        vecs.push_back('{1'b0, 3'd7, 32'h0, 32'h0, "unmapped7"});
        vecs.push_back('{1'b1, 3'd2, 32'h0, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd2, 32'h0, 32'h0, "lim_zero"});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            else            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        chk("tbl_no_pulse", 32'(start_rt), 32'h0);

        // 1: normal frame, rt_done 10 cycles after start_rt
        do_reset();
        p0 = pulses;
        chk("t1_pre_start", 32'(start_rt), 32'h0);
        wr(3'd0, 32'h3);
        chk("t1_start_hi", 32'(start_rt), 32'h1);
        cyc(1);
        chk("t1_start_lo", 32'(start_rt), 32'h0);
        cyc(9);
        rt_done = 1'b1;
        cyc(1);
        rt_done = 1'b0;
        chk("t1_irq_lag", 32'(irq), 32'h0);
        cyc(1);
        chk("t1_irq_hi", 32'(irq), 32'h1);
        rd(3'd1, 32'hA, "t1_status");
        rd(3'd3, 32'd10, "t1_cycles");
        rd(3'd4, 32'd1, "t1_frames");
        chk("t1_pulses", pulses - p0, 32'd1);

        // 2: timeout after 5 RUN cycles, then CLEAR
        do_reset();
        wr(3'd2, 32'd5);
        wr(3'd0, 32'h3);
        cyc(5);
        rd(3'd1, 32'h1, "t2_busy");
        rd(3'd1, 32'h6, "t2_status");
        rd(3'd3, 32'd5, "t2_cycles");
        rd(3'd4, 32'd1, "t2_frames");
        chk("t2_irq_hi", 32'(irq), 32'h1);
        wr(3'd0, 32'h4);
        cyc(1);
        chk("t2_irq_lo", 32'(irq), 32'h0);
        rd(3'd1, 32'h0, "t2_cleared");

        // 3: START hammered during RUN
        do_reset();
        p0 = pulses;
        wr(3'd0, 32'h1);
        write = 1'b1; address = 3'd0; writedata = 32'h1;
        cyc(6);
        rt_done = 1'b1;
        cyc(1);
        rt_done = 1'b0; write = 1'b0;
        cyc(2);
        chk("t3_pulses", pulses - p0, 32'd1);
        rd(3'd4, 32'd1, "t3_frames");
        rd(3'd3, 32'd6, "t3_cycles");
        rd(3'd1, 32'h2, "t3_status");

        // 4: rt_done in the same cycle the limit is reached
        do_reset();
        wr(3'd2, 32'd5);
        wr(3'd0, 32'h1);
        cyc(5);
        rt_done = 1'b1;
        cyc(1);
        rt_done = 1'b0;
        rd(3'd1, 32'h2, "t4_status");
        rd(3'd3, 32'd5, "t4_cycles");
        rd(3'd4, 32'd1, "t4_frames");

        // 5: CLEAR coincident with completion, then CLEAR+START
        do_reset();
        wr(3'd0, 32'h3);
        cyc(3);
        rt_done = 1'b1;
        write = 1'b1; address = 3'd0; writedata = 32'h4;
        cyc(1);
        rt_done = 1'b0; write = 1'b0;
        rd(3'd1, 32'h2, "t5_done_kept");
        wr(3'd0, 32'h5);
        chk("t5_start_hi", 32'(start_rt), 32'h1);
        rd(3'd1, 32'h1, "t5_restart");

        // 6: reset mid-run, FRAMES wrap, unmapped read
        do_reset();
        p0 = pulses;
        wr(3'd0, 32'h1);
        cyc(8);
        rd(3'd3, 32'd7, "t6_cycles7");
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_no_start", 32'(start_rt), 32'h0);
        rd(3'd1, 32'h0, "t6_status");
        rd(3'd3, 32'h0, "t6_cycles");
        rd(3'd4, 32'h0, "t6_frames");
        cyc(3);
        chk("t6_pulses", pulses - p0, 32'd1);
        force dut.frames_q = 16'hFFFF;
        cyc(1);
        release dut.frames_q;
        rd(3'd4, 32'hFFFF, "t6_frames_max");
        wr(3'd0, 32'h1);
        cyc(2);
        rt_done = 1'b1;
        cyc(1);
        rt_done = 1'b0;
        rd(3'd4, 32'h0, "t6_frames_wrap");
        rd(3'd6, 32'h0, "t6_unmapped6");
        rd(3'd1, 32'h2, "t6_status_done");

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
